// File: rtl/stream_upsize_pack.sv
// Narrow-to-wide stream packer: gathers T_DATA_RATIO input beats into one output word.
// A word is closed early by s_last_i. The output is a single registered slot.
module stream_upsize_pack #(
    parameter int T_DATA_WIDTH = 8,
    parameter int T_DATA_RATIO = 4,
    parameter int LANE_ORDER   = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [T_DATA_WIDTH-1:0] s_data_i,
    input  logic                    s_last_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    output logic [T_DATA_WIDTH-1:0] m_data_o [T_DATA_RATIO],
    output logic [T_DATA_RATIO-1:0] m_keep_o,
    output logic                    m_last_o,
    output logic                    m_valid_o,
    input  logic                    m_ready_i
);

    localparam int               CNT_W   = $clog2(T_DATA_RATIO);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(T_DATA_RATIO - 1);

    logic [CNT_W-1:0]        r_cnt;
    logic [T_DATA_WIDTH-1:0] r_asm_data [T_DATA_RATIO];
    logic [T_DATA_RATIO-1:0] r_asm_keep;
    logic [T_DATA_WIDTH-1:0] r_out_data [T_DATA_RATIO];
    logic [T_DATA_RATIO-1:0] r_out_keep;
    logic                    r_out_last;
    logic                    r_out_valid;

    logic                    w_s_ready;
    logic                    w_accept;
    logic                    w_complete;
    logic [CNT_W-1:0]        w_lane;
    logic [T_DATA_RATIO-1:0] w_lane_hot;
    logic [T_DATA_RATIO-1:0] w_word_keep;
    logic [T_DATA_WIDTH-1:0] w_word_data [T_DATA_RATIO];

    // The slot can take a new word whenever it is empty or being drained this cycle.
    assign w_s_ready  = !r_out_valid || m_ready_i;
    assign w_accept   = s_valid_i && w_s_ready;
    assign w_complete = (r_cnt == CNT_MAX) || s_last_i;
    assign w_lane     = (LANE_ORDER == 0) ? r_cnt : CNT_MAX - r_cnt;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_lane_hot = '0;
        for (int i = 0; i < T_DATA_RATIO; i++) begin
            w_lane_hot[i] = (CNT_W'(i) == w_lane);
        end
        w_word_keep = r_asm_keep | w_lane_hot;
        // Lanes not yet written are forced to zero so stale assembly data never leaks out.
        for (int i = 0; i < T_DATA_RATIO; i++) begin
            w_word_data[i] = w_lane_hot[i] ? s_data_i
                           : (r_asm_keep[i] ? r_asm_data[i] : '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the lane arrays are plain flops, not RAM, so they are cleared by reset like any register.
            r_cnt       <= '0;
            r_asm_keep  <= '0;
            r_out_keep  <= '0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
            for (int i = 0; i < T_DATA_RATIO; i++) begin
                r_asm_data[i] <= '0;
                r_out_data[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            if (w_accept && w_complete) begin
                r_out_data  <= w_word_data;
                r_out_keep  <= w_word_keep;
                r_out_last  <= s_last_i;
                r_out_valid <= 1'b1;
                r_asm_keep  <= '0;
                r_cnt       <= '0;
            end else begin
                if (w_accept) begin
                    r_asm_data[w_lane] <= s_data_i;
                    r_asm_keep         <= w_word_keep;
                    r_cnt              <= r_cnt + CNT_W'(1);
                end
                if (r_out_valid && m_ready_i) begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    assign s_ready_o = w_s_ready;
    assign m_data_o  = r_out_data;
    assign m_keep_o  = r_out_keep;
    assign m_last_o  = r_out_last;
    assign m_valid_o = r_out_valid;

endmodule
